// File: rtl/maxpool_engine_if.sv
// Control and memory-port bundle for the max-pooling engine.
// The engine drives the master side; the top-level bus mux (or a bench) takes the slave side.
interface maxpool_engine_if #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 12
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        input  start, rd_data,
        output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );

    modport slave (
        output start, rd_data,
        input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/maxpool_engine.sv
// 2x2 stride-2 max pooling of an IMG_W x IMG_W map into raster-ordered (IMG_W/2)^2 outputs.
// Six cycles per output window: four reads, one absorb cycle for the last sample, one write.
module maxpool_engine #(
    parameter int IMG_W  = 64,
    parameter int DATA_W = 20,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    maxpool_engine_if.master  bus
);
    localparam int LG   = $clog2(IMG_W);
    localparam int HLG  = LG - 1;
    localparam int OI_W = 2 * HLG;

    typedef enum logic [2:0] {IDLE, RD, LAST, WR, FIN} state_t;

    state_t                   state;
    logic [OI_W-1:0]          oi;
    logic [1:0]               ph;
    logic signed [DATA_W-1:0] acc;
    logic signed [DATA_W-1:0] sample;
    logic signed [DATA_W-1:0] acc_max;

    // Window address is {row, ph[1], col, ph[0]}: row stride 2*IMG_W, col stride 2.
    function automatic logic [ADDR_W-1:0] win_addr(input logic [OI_W-1:0] idx,
                                                   input logic [1:0]      p);
        return ADDR_W'({idx[OI_W-1:HLG], p[1], idx[HLG-1:0], p[0]});
    endfunction

    assign sample  = bus.rd_data;
    // Strictly greater replaces, so a tie keeps the accumulator.
    assign acc_max = (sample > acc) ? sample : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            oi          <= '0;
            ph          <= '0;
            acc         <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rd_en   <= 1'b0;
            bus.rd_addr <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= RD;
                        ph          <= '0;
                        oi          <= '0;
                        bus.busy    <= 1'b1;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= win_addr('0, 2'd0);
                    end
                end
                RD: begin
                    // rd_data trails the strobe by one cycle, so ph=1 sees the first sample.
                    if (ph == 2'd1)
                        acc <= sample;
                    else if (ph != 2'd0)
                        acc <= acc_max;
                    if (ph == 2'd3) begin
                        state       <= LAST;
                        ph          <= '0;
                        bus.rd_en   <= 1'b0;
                        bus.rd_addr <= '0;
                    end else begin
                        ph          <= ph + 2'd1;
                        bus.rd_addr <= win_addr(oi, ph + 2'd1);
                    end
                end
                LAST: begin
                    acc         <= acc_max;
                    state       <= WR;
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= ADDR_W'(oi);
                    bus.wr_data <= acc_max;
                end
                WR: begin
                    bus.wr_en   <= 1'b0;
                    bus.wr_addr <= '0;
                    bus.wr_data <= '0;
                    if (&oi) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                    end else begin
                        oi          <= oi + 1'b1;
                        state       <= RD;
                        ph          <= '0;
                        bus.rd_en   <= 1'b1;
                        bus.rd_addr <= win_addr(OI_W'(oi + 1'b1), 2'd0);
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    oi       <= '0;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_engine.sv
// Cycle-exact bench for maxpool_engine: random and patterned frames against a pooled-max reference.
module tb_maxpool_engine;
    localparam int IMG_W  = 64;
    localparam int DATA_W = 20;
    localparam int ADDR_W = 12;
    localparam int W2     = IMG_W / 2;
    localparam int NWIN   = W2 * W2;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int T_DONE = 6 * NWIN + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    maxpool_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    maxpool_engine #(.IMG_W(IMG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    logic signed [DATA_W-1:0] mem      [NPIX];
    logic signed [DATA_W-1:0] exp_pool [NWIN];
    logic        [DATA_W-1:0] got      [NWIN];
    logic        [DATA_W-1:0] prev     [NWIN];
    int n_chk = 0;
    int n_err = 0;

    // Layer-0 memory: data valid the cycle after the strobe, garbage otherwise.
    always @(posedge clk)
        bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : DATA_W'($urandom);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] pack(input logic b, input logic d, input logic re,
                                         input logic [ADDR_W-1:0] ra, input logic we,
                                         input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        return 64'({b, d, re, ra, we, wa, wd});
    endfunction

    function automatic logic [63:0] obs_now();
        return pack(bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data);
    endfunction

    task automatic build_ref();
        for (int n = 0; n < NWIN; n++) begin
            int b;
            logic signed [DATA_W-1:0] m;
            b = 2 * (n / W2) * IMG_W + 2 * (n % W2);
            m = mem[b];
            if (mem[b + 1] > m)         m = mem[b + 1];
            if (mem[b + IMG_W] > m)     m = mem[b + IMG_W];
            if (mem[b + IMG_W + 1] > m) m = mem[b + IMG_W + 1];
            exp_pool[n] = m;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < NPIX; a++)
            mem[a] = $urandom_range(0, 1) ? DATA_W'($urandom) : DATA_W'(int'($urandom_range(0, 6)) - 3);
    endtask

    // Called at a negedge; start is sampled at the following edge (cycle 0).
    task automatic run_frame(input int run, input bit hold, input int pa, input int pb, input int abort_at);
        int nrd = 0, nwr = 0, nov = 0;
        for (int i = 0; i < NWIN; i++) got[i] = '0;
        bus.start = 1'b1;
        @(posedge clk);
        for (int rel = 1; rel <= T_DONE + 1; rel++) begin
            logic b = 0, d = 0, re = 0, we = 0;
            logic [ADDR_W-1:0] ra = '0, wa = '0;
            logic [DATA_W-1:0] wd = '0;
            @(negedge clk);
            if (rel <= 6 * NWIN) begin
                int p, n;
                p = (rel - 1) % 6;
                n = (rel - 1) / 6;
                b = 1;
                if (p < 4) begin
                    re = 1;
                    ra = ADDR_W'(2 * (n / W2) * IMG_W + 2 * (n % W2) + (p / 2) * IMG_W + (p % 2));
                end
                if (p == 5) begin
                    we = 1;
                    wa = ADDR_W'(n);
                    wd = exp_pool[n];
                end
            end else if (rel == T_DONE) begin
                b = 1;
                d = 1;
            end
            chk($sformatf("run%0d cyc%0d", run, rel), obs_now(), pack(b, d, re, ra, we, wa, wd));
            if (bus.wr_en && int'(bus.wr_addr) < NWIN) got[int'(bus.wr_addr)] = bus.wr_data;
            nrd += int'(bus.rd_en);
            nwr += int'(bus.wr_en);
            nov += int'(bus.rd_en & bus.wr_en);
            bus.start = (rel == pa || rel == pb) ? 1'b1 : hold;
            if (rel == abort_at) begin
                reset = 1'b1;
                #1;
                chk($sformatf("run%0d rst_async", run), obs_now(), 64'd0);
                return;
            end
        end
        chk($sformatf("run%0d rd_count", run), 64'(nrd), 64'(NPIX));
        chk($sformatf("run%0d wr_count", run), 64'(nwr), 64'(NWIN));
        chk($sformatf("run%0d overlap", run), 64'(nov), 64'd0);
    endtask

    initial begin
        int diff;
        reset = 1'b1;
        bus.start = 1'b0;
        for (int a = 0; a < NPIX; a++) mem[a] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", obs_now(), 64'd0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_outs", obs_now(), 64'd0);
        end

        // Random frame with planted signed, all-zero and extreme-value windows.
        fill_random();
        mem[0] = -20'sd3; mem[1] = -20'sd1; mem[64] = -20'sd8; mem[65] = -20'sd2;
        mem[2] = '0; mem[3] = '0; mem[66] = '0; mem[67] = '0;
        mem[4] = 20'h80000; mem[5] = 20'h7FFFF; mem[68] = 20'hFFFFF; mem[69] = '0;
        build_ref();
        run_frame(1, 1'b0, -1, -1, -1);
        chk("signed_win", 64'(got[0]), 64'h0FFFFF);
        chk("zero_win", 64'(got[1]), 64'h0);
        chk("extreme_win", 64'(got[2]), 64'h07FFFF);

        // Linear map with stray start pulses mid-run.
        for (int a = 0; a < NPIX; a++) mem[a] = DATA_W'(a);
        build_ref();
        run_frame(2, 1'b0, 100, 3000, -1);
        chk("lin_0_0",   64'(got[0]),           64'((0 * 2 + 1) * 64 + 0 * 2 + 1));
        chk("lin_0_31",  64'(got[31]),          64'((0 * 2 + 1) * 64 + 31 * 2 + 1));
        chk("lin_31_0",  64'(got[31 * 32]),     64'((31 * 2 + 1) * 64 + 0 * 2 + 1));
        chk("lin_31_31", 64'(got[31 * 32 + 31]), 64'((31 * 2 + 1) * 64 + 31 * 2 + 1));
        chk("lin_13_7",  64'(got[13 * 32 + 7]), 64'((13 * 2 + 1) * 64 + 7 * 2 + 1));

        // Reset at cycle 2000, then a clean restart.
        run_frame(3, 1'b0, -1, -1, 2000);
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", obs_now(), 64'd0);
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst", obs_now(), 64'd0);
        end
        run_frame(4, 1'b0, -1, -1, -1);
        chk("restart_last", 64'(got[NWIN - 1]), 64'((31 * 2 + 1) * 64 + 31 * 2 + 1));

        // Back-to-back runs with start held high.
        fill_random();
        build_ref();
        run_frame(5, 1'b1, -1, -1, -1);
        for (int i = 0; i < NWIN; i++) prev[i] = got[i];
        run_frame(6, 1'b0, -1, -1, -1);
        diff = 0;
        for (int i = 0; i < NWIN; i++) if (prev[i] !== got[i]) diff++;
        chk("b2b_same", 64'(diff), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
